hazard_unit_param: RTL and testbench

- Parametrised ID-stage hazard detection unit for the 5-stage MIPS pipeline; generational successor to the single-flag load-use/branch detector.
- Compares ID-stage sources against EX and MEM destinations, computes the stall depth (0, 1 or 2 cycles) and holds PC/IF-ID while inserting ID/EX bubbles.
- Adds three behaviours: register-0 exclusion, a deterministic stall counter FSM, and a saturating stall-cycle statistics counter.

---
 rtl/hazard_unit_param.sv | 121 ++++++++++++
 tb/tb_hazard_unit_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_param.sv
// rtl/hazard_unit_param.sv - ID-stage hazard detector with stall-depth FSM and stall statistics
module hazard_unit_param #(
  parameter int REG_AW   = 5,
  parameter int OP_W     = 6,
  parameter int RTYPE_OP = 0,
  parameter int STORE_OP = 43,
  parameter int BEQ_OP   = 4,
  parameter int BNE_OP   = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              pipe_freeze,
  input  logic              stat_clr,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stat_q, stat_d;

  logic       is_br, rt_used;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;
  logic       hit_ex, hit_mem;
  logic [1:0] need;
  logic       stall;

  assign is_br   = (op_id == OP_W'(BEQ_OP)) || (op_id == OP_W'(BNE_OP));
  assign rt_used = is_br || (op_id == OP_W'(RTYPE_OP)) || (op_id == OP_W'(STORE_OP));

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  assign rs_ex  = (rs_id == ex_dst)  && (ex_dst  != '0);
  assign rt_ex  = (rt_id == ex_dst)  && (ex_dst  != '0) && rt_used;
  assign rs_mem = (rs_id == mem_dst) && (mem_dst != '0);
  assign rt_mem = (rt_id == mem_dst) && (mem_dst != '0) && rt_used;

  assign hit_ex  = (ex_reg_write || ex_mem_read) && (rs_ex || rt_ex);
  assign hit_mem = mem_mem_read && (rs_mem || rt_mem);

  always_comb begin
    need = 2'd0;
    if (is_br && hit_ex && ex_mem_read) begin
      need = 2'd2;
    end else if (is_br && (hit_ex || hit_mem)) begin
      need = 2'd1;
    end else if (!is_br && hit_ex && ex_mem_read) begin
      need = 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  // The first stall cycle is spent in IDLE; HOLD covers the remaining cnt cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (need != 2'd0 && !pipe_freeze) begin
          cnt_d = need - 2'd1;
          if (need == 2'd2) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!pipe_freeze) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (state_q == HOLD) || (need != 2'd0);
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (stall && !pipe_freeze && (stat_q != '1)) begin
      stat_d = stat_q + 1'b1;
    end
  end

  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign id_ex_bubble = stall;
  assign stall_cycles = stat_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// tb/tb_hazard_unit_param.sv - scoreboard bench for hazard_unit_param against a stall-budget model
module tb_hazard_unit_param;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       op_id = '0;
  logic [4:0]       rs_id = '0, rt_id = '0, ex_dst = '0, mem_dst = '0;
  logic             ex_reg_write = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0;
  logic             pipe_freeze = 1'b0, stat_clr = 1'b0;
  logic             pc_hold, if_id_hold, id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles;

  hazard_unit_param #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op_id(op_id), .rs_id(rs_id), .rt_id(rt_id),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .pipe_freeze(pipe_freeze),
    .stat_clr(stat_clr), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .id_ex_bubble(id_ex_bubble), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    s;
    int    c;
    string tag;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;

  // Model state: cycles of stall still owed to the instruction in ID, and the statistics count.
  int rem  = 0;
  int mcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stall depth as the worst penalty over each producer the instruction depends on.
  function automatic int model_need(input int op, input int rs, input int rt,
                                    input bit exw, input bit exr, input int exd,
                                    input bit memr, input int memd);
    bit br, uses_rt, dep_ex, dep_mem;
    int n_ex, n_mem;
    br      = (op == 4) || (op == 5);
    uses_rt = br || (op == 0) || (op == 43);
    dep_ex  = (exd != 0) && ((rs == exd) || (uses_rt && rt == exd));
    dep_mem = (memd != 0) && ((rs == memd) || (uses_rt && rt == memd));
    n_ex = 0;
    if (dep_ex && exr) n_ex = br ? 2 : 1;
    else if (dep_ex && exw) n_ex = br ? 1 : 0;
    n_mem = (dep_mem && memr && br) ? 1 : 0;
    return (n_ex > n_mem) ? n_ex : n_mem;
  endfunction

  task automatic step(input string tag, input int op, input int rs, input int rt,
                      input bit exw, input bit exr, input int exd,
                      input bit memr, input int memd, input bit frz, input bit clr);
    int   n;
    exp_t e;
    op_id = 6'(op); rs_id = 5'(rs); rt_id = 5'(rt);
    ex_reg_write = exw; ex_mem_read = exr; ex_dst = 5'(exd);
    mem_mem_read = memr; mem_dst = 5'(memd);
    pipe_freeze = frz; stat_clr = clr;
    n = model_need(op, rs, rt, exw, exr, exd, memr, memd);
    e.s = (rem > 0) || (n > 0);
    e.c = mcnt;
    e.tag = tag;
    q.push_back(e);
    if (!frz) begin
      if (rem > 0) rem--;
      else if (n > 0) rem = n - 1;
      if (e.s && mcnt < SAT) mcnt++;
    end
    if (clr) mcnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input string tag);
    step(tag, 8, 1, 2, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".pc_hold"}, int'(pc_hold), int'(e.s));
      chk({e.tag, ".if_id_hold"}, int'(if_id_hold), int'(e.s));
      chk({e.tag, ".id_ex_bubble"}, int'(id_ex_bubble), int'(e.s));
      chk({e.tag, ".stall_cycles"}, int'(stall_cycles), e.c);
    end
  end

  initial begin
    #12;
    chk("reset.pc_hold", int'(pc_hold), 0);
    chk("reset.id_ex_bubble", int'(id_ex_bubble), 0);
    chk("reset.stall_cycles", int'(stall_cycles), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    step("ld_use", 0, 3, 5, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    idle_step("ld_use_after");

    step("beq_ld_a", 4, 3, 9, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    step("beq_ld_b", 4, 3, 9, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle_step("beq_ld_after");

    step("beq_alu", 4, 1, 7, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0, 1'b0);
    idle_step("beq_alu_after");
    step("bne_mem", 5, 1, 7, 1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
    idle_step("bne_mem_after");
    step("beq_both_a", 4, 1, 7, 1'b0, 1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
    step("beq_both_b", 4, 1, 7, 1'b0, 1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
    idle_step("beq_both_after");

    step("r0_load", 0, 0, 0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    step("addi_rt", 8, 2, 6, 1'b0, 1'b1, 6, 1'b0, 0, 1'b0, 1'b0);

    step("frz_0", 4, 3, 0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("frz_mid", 4, 3, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    step("frz_4", 4, 3, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle_step("frz_after");

    for (int i = 0; i < SAT + 3; i++)
      step("sat", 0, 3, 0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    idle_step("sat_hold");
    step("clr_stall", 0, 3, 0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b1);
    idle_step("clr_after");

    // Asynchronous reset while the FSM is in HOLD with the hazard still presented.
    step("rst_pre", 4, 3, 0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_hold.pc_hold", int'(pc_hold), 0);
    chk("rst_hold.if_id_hold", int'(if_id_hold), 0);
    chk("rst_hold.stall_cycles", int'(stall_cycles), 0);
    @(posedge clk); #1;
    ex_mem_read = 1'b0; ex_dst = '0;
    rst = 1'b0;
    rem = 0;
    mcnt = 0;
    idle_step("rst_after");

    for (int i = 0; i < 400; i++) begin
      int ops[7] = '{0, 43, 4, 5, 8, 35, 0};
      int op;
      op = ops[$urandom_range(6)];
      if ($urandom_range(9) == 0) op = $urandom_range(63);
      step("rand", op, $urandom_range(3), $urandom_range(3),
           1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3),
           1'($urandom_range(1)), $urandom_range(3),
           $urandom_range(5) == 0, $urandom_range(19) == 0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
